// File: rtl/cbus_mem_responder_pkg.sv
// Shared cache-bus types, responder FSM states and the burst next-address helper.
// Used by cbus_mem_responder (optional feature macro: CBUS_MEM_BACKPRESSURE_EN).
package cbus_mem_responder_pkg;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   // Burst length is encoded as beats-1, so MLEN256 still fits in 8 bits.
   typedef logic [7:0] mlen_t;
   localparam mlen_t MLEN1   = 8'd0;
   localparam mlen_t MLEN4   = 8'd3;
   localparam mlen_t MLEN8   = 8'd7;
   localparam mlen_t MLEN256 = 8'd255;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'd0,
      AXI_BURST_INCR  = 2'd1,
      AXI_BURST_WRAP  = 2'd2
   } axi_burst_type_t;

   typedef struct packed {
      logic            valid;
      logic            is_write;
      msize_t          size;
      logic [63:0]     addr;
      logic [7:0]      strobe;
      logic [63:0]     data;
      mlen_t           len;
      axi_burst_type_t burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

   localparam int CBUS_REQ_W  = $bits(cbus_req_t);
   localparam int CBUS_RESP_W = $bits(cbus_resp_t);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2,
      DONE  = 2'd3
   } cbus_mem_state_t;

   // Address of the beat following addr; a reserved burst encoding behaves as FIXED.
   function automatic logic [63:0] cbus_next_addr(input logic [63:0]     addr,
                                                  input msize_t          size,
                                                  input mlen_t           len,
                                                  input axi_burst_type_t burst);
      logic [63:0] step;
      logic [63:0] mask;
      step = 64'd1 << size;
      mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
      case (burst)
         AXI_BURST_INCR: cbus_next_addr = addr + step;
         AXI_BURST_WRAP: cbus_next_addr = (addr & ~mask) | ((addr + step) & mask);
         default:        cbus_next_addr = addr;
      endcase
   endfunction

endpackage

// File: rtl/cbus_burst_addr.sv
// Beat address generator for the memory responder: optionally steps the address
// to the next beat and maps it onto a word index with an in-range flag.
module cbus_burst_addr
   import cbus_mem_responder_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
)
(
   input  logic [63:0]                  addr,
   input  logic [1:0]                   size,
   input  logic [7:0]                   len,
   input  logic [1:0]                   burst,
   input  logic                         advance,
   output logic [63:0]                  beat_addr,
   output logic [$clog2(MEM_WORDS)-1:0] word_idx,
   output logic                         in_range
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [63:0] offset;

   // The range test works on the offset from the base so that a window ending
   // at the very top of the 64-bit space cannot overflow the comparison.
   always_comb begin
      beat_addr = advance ? cbus_next_addr(addr, msize_t'(size), len, axi_burst_type_t'(burst))
                          : addr;
      offset    = beat_addr - BASE_ADDR;
      in_range  = (beat_addr >= BASE_ADDR) && (offset < (64'(MEM_WORDS) << 3));
      word_idx  = offset[3 +: IDX_W];
   end

endmodule

// File: rtl/cbus_mem_responder.sv
// Cache-bus responder backed by an on-chip 64-bit word array (FIXED/INCR/WRAP bursts).
// Optional feature macro: CBUS_MEM_BACKPRESSURE_EN inserts pseudo-random beat stalls.
module cbus_mem_responder
   import cbus_mem_responder_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
   parameter int          FIRST_LAT = 2
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [CBUS_REQ_W-1:0]  creq,
   output logic [CBUS_RESP_W-1:0] cresp
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int LAT_W = (FIRST_LAT > 1) ? $clog2(FIRST_LAT) : 1;

   cbus_req_t       req;
   cbus_resp_t      respReg, respNext;
   cbus_mem_state_t state, stateNext;
   logic [LAT_W-1:0] latCnt, latCntNext;
   mlen_t           beatCnt, beatCntNext, lenQ;
   logic [63:0]     beatAddr, beatAddrNext, presentAddr;
   logic [1:0]      sizeQ, burstQ;
   logic            isWriteQ;
   logic [IDX_W-1:0] wrIdx, wrIdxNext, presentIdx;
   logic            wrOk, wrOkNext, presentInRange;
   logic            advance, beatSlot, present, stall, memWrite;
   logic [63:0]     mem [MEM_WORDS];

   assign req   = cbus_req_t'(creq);
   assign cresp = respReg;

   // Moving to the next beat happens exactly when the master consumed a
   // non-final beat; kept outside the FSM block so the address path that
   // feeds the response has no feedback through it.
   assign advance = (state == BURST) && req.valid && respReg.ready && !respReg.last;

   cbus_burst_addr #(
      .MEM_WORDS (MEM_WORDS),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr (
      .addr      (beatAddr),
      .size      (sizeQ),
      .len       (lenQ),
      .burst     (burstQ),
      .advance   (advance),
      .beat_addr (presentAddr),
      .word_idx  (presentIdx),
      .in_range  (presentInRange)
   );

`ifdef CBUS_MEM_BACKPRESSURE_EN
   logic [15:0] lfsr;
   logic [1:0]  stallRun;

   assign stall = (lfsr[1:0] == 2'b00) && (stallRun != 2'd3);

   // The LFSR advances on every beat opportunity; after three stalled slots
   // in a row the next slot is forced to carry a beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr     <= 16'hACE1;
         stallRun <= 2'd0;
      end else if (beatSlot) begin
         lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         stallRun <= stall ? stallRun + 2'd1 : 2'd0;
      end
   end
`else
   assign stall = 1'b0;
`endif

   // Next-state logic. beatCnt/beatAddr always name the beat that is on the
   // bus or waiting to go out; a beat slot is any edge that may load a new
   // beat into the registered response.
   always_comb begin
      stateNext    = state;
      latCntNext   = latCnt;
      beatCntNext  = beatCnt;
      beatAddrNext = beatAddr;
      beatSlot     = 1'b0;
      memWrite     = 1'b0;
      case (state)
         IDLE: begin
            if (req.valid) begin
               stateNext    = WAIT;
               latCntNext   = LAT_W'(FIRST_LAT - 1);
               beatCntNext  = '0;
               beatAddrNext = req.addr;
            end
         end
         WAIT: begin
            if (!req.valid) begin
               stateNext = IDLE;
            end else if (latCnt == '0) begin
               stateNext = BURST;
               beatSlot  = 1'b1;
            end else begin
               latCntNext = latCnt - LAT_W'(1);
            end
         end
         BURST: begin
            if (!req.valid) begin
               stateNext = IDLE;
            end else begin
               memWrite = respReg.ready && wrOk;
               if (respReg.ready && respReg.last) begin
                  stateNext = DONE;
               end else begin
                  beatSlot = 1'b1;
                  if (advance) begin
                     beatCntNext  = beatCnt + 8'd1;
                     beatAddrNext = presentAddr;
                  end
               end
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign present = beatSlot && !stall;

   // Build the next registered response. Read data is looked up here so that
   // it appears together with ready; for writes the target index is stored so
   // the commit can happen in the cycle the beat is shown.
   always_comb begin
      respNext  = '0;
      wrIdxNext = wrIdx;
      wrOkNext  = 1'b0;
      if (present) begin
         respNext.ready = 1'b1;
         respNext.last  = (beatCntNext == lenQ);
         respNext.data  = (!isWriteQ && presentInRange) ? mem[presentIdx] : '0;
         wrIdxNext      = presentIdx;
         wrOkNext       = isWriteQ && presentInRange;
      end
   end

   // FSM and response registers; the request attributes are captured once at
   // acceptance and used for the whole burst.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         latCnt   <= '0;
         beatCnt  <= '0;
         beatAddr <= '0;
         respReg  <= '0;
         wrIdx    <= '0;
         wrOk     <= 1'b0;
         isWriteQ <= 1'b0;
         sizeQ    <= '0;
         lenQ     <= '0;
         burstQ   <= '0;
      end else begin
         state    <= stateNext;
         latCnt   <= latCntNext;
         beatCnt  <= beatCntNext;
         beatAddr <= beatAddrNext;
         respReg  <= respNext;
         wrIdx    <= wrIdxNext;
         wrOk     <= wrOkNext;
         if (state == IDLE && req.valid) begin
            isWriteQ <= req.is_write;
            sizeQ    <= req.size;
            lenQ     <= req.len;
            burstQ   <= req.burst;
         end
      end
   end

   // Word array with byte-lane strobes. It is never cleared, and a reset in
   // the commit cycle suppresses the write.
   always_ff @(posedge clk) begin
      if (memWrite && !reset) begin
         for (int b = 0; b < 8; b++) begin
            if (req.strobe[b]) begin
               mem[wrIdx][8*b +: 8] <= req.data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Self-checking bench for cbus_mem_responder: directed bursts plus random traffic
// compared against a word-array reference model held in the bench.
module tb_cbus_mem_responder;
   import cbus_mem_responder_pkg::*;

   localparam int          MEM_WORDS = 4096;
   localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;
   localparam int          FIRST_LAT = 2;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [CBUS_REQ_W-1:0]  creq;
   logic [CBUS_RESP_W-1:0] cresp;
   cbus_req_t              req = '0;
   cbus_resp_t             resp;

   logic [63:0] model [MEM_WORDS];
   logic [63:0] wdata [256];
   logic [7:0]  wstrb [256];
   int          checks = 0;
   int          failures = 0;

   assign creq = req;
   assign resp = cbus_resp_t'(cresp);

   always #5 clk = ~clk;

   cbus_mem_responder #(
      .MEM_WORDS (MEM_WORDS),
      .BASE_ADDR (BASE),
      .FIRST_LAT (FIRST_LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .creq  (creq),
      .cresp (cresp)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [65:0] observed, input logic [65:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Address of beat k computed directly from the start address: FIXED stays,
   // INCR steps linearly, WRAP walks modulo the burst's total byte span.
   function automatic logic [63:0] beatAddress(input logic [63:0] start, input int size,
                                               input int len, input int burst, input int k);
      logic [63:0] step, total, base;
      step  = 64'd1 << size;
      total = 64'(len + 1) * step;
      base  = start - (start % total);
      case (burst)
         1:       return start + 64'(k) * step;
         2:       return base + ((start - base + 64'(k) * step) % total);
         default: return start;
      endcase
   endfunction

   function automatic bit inWindow(input logic [63:0] a);
      return (a >= BASE) && (a < BASE + 64'(MEM_WORDS) * 64'd8);
   endfunction

   function automatic logic [63:0] modelRead(input logic [63:0] a);
      if (!inWindow(a)) return 64'd0;
      return model[(a - BASE) / 8];
   endfunction

   task automatic modelWrite(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
      int idx;
      if (inWindow(a)) begin
         idx = int'((a - BASE) / 8);
         for (int b = 0; b < 8; b++) begin
            if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   // Plays the master for one burst and checks every response cycle. Write
   // data for beat k is held until the cycle after ready is seen for it; the
   // burst can be cut short after abortAfter consumed beats, by dropping
   // valid or by a reset.
   task automatic applyStimulus(input bit isWrite, input int size, input int len, input int burst,
                                input logic [63:0] addr, input int abortAfter, input bit abortReset,
                                input string tag);
      int  k;
      int  stallRun;
      bit  prevReady, prevLast, finished;
      req          = '0;
      req.valid    = 1'b1;
      req.is_write = isWrite;
      req.size     = msize_t'(size);
      req.addr     = addr;
      req.len      = mlen_t'(len);
      req.burst    = axi_burst_type_t'(burst);
      req.data     = isWrite ? wdata[0] : 64'd0;
      req.strobe   = isWrite ? wstrb[0] : 8'd0;
      k = 0; stallRun = 0; prevReady = 0; prevLast = 0; finished = 0;
      for (int i = 0; i < 800 && !finished; i++) begin
         @(posedge clk); #1;
         if (prevReady) begin
            if (isWrite) modelWrite(beatAddress(addr, size, len, burst, k), wdata[k], wstrb[k]);
            k++;
            if (prevLast) begin
               req.valid = 1'b0;
               checkOutput({tag, "_done"}, resp, '0);
               finished = 1;
            end else if (k == abortAfter) begin
               if (abortReset) reset = 1'b1;
               else req.valid = 1'b0;
               @(posedge clk); #1;
               checkOutput({tag, "_abort"}, resp, '0);
               reset = 1'b0;
               req.valid = 1'b0;
               finished = 1;
            end else if (isWrite) begin
               req.data   = wdata[k];
               req.strobe = wstrb[k];
            end
         end
         if (!finished) begin
            if (resp.ready) begin
               checkOutput({tag, "_data"}, resp.data,
                           isWrite ? 64'd0 : modelRead(beatAddress(addr, size, len, burst, k)));
               checkOutput({tag, "_last"}, resp.last, (k == len));
`ifdef CBUS_MEM_BACKPRESSURE_EN
               checkOutput({tag, "_stallrun"}, (stallRun <= 3), 1);
`else
               checkOutput({tag, "_time"}, i, FIRST_LAT + k);
`endif
               stallRun = 0;
            end else begin
               checkOutput({tag, "_quiet"}, resp, '0);
               if (i >= FIRST_LAT) stallRun++;
            end
            prevReady = resp.ready;
            prevLast  = resp.last;
         end
      end
      if (!finished) begin
         checkOutput({tag, "_timeout"}, 0, 1);
         req.valid = 1'b0;
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput({tag, "_settle"}, resp, '0);
   endtask

   // Directed scenarios first, then random bursts against the model.
   initial begin
      int size, len, burst, abortAfter;
      bit isWrite;
      logic [63:0] addr;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_resp", resp, '0);
      reset = 1'b0;

      // Give every word a known value with full-length bursts.
      for (int blk = 0; blk < 16; blk++) begin
         for (int j = 0; j < 256; j++) begin
            wdata[j] = {$urandom, $urandom};
            wstrb[j] = 8'hFF;
         end
         applyStimulus(1, 3, 255, 1, BASE + 64'(blk) * 64'd2048, -1, 0, "fill");
      end

      wdata[0] = 64'h1122_3344_5566_7788; wstrb[0] = 8'hFF;
      applyStimulus(1, 3, 0, 1, BASE, -1, 0, "t1_wr");
      applyStimulus(0, 3, 0, 1, BASE, -1, 0, "t1_rd");
      checkOutput("t1_model", model[0], 64'h1122_3344_5566_7788);

      for (int j = 0; j < 4; j++) begin
         wdata[j] = 64'(j + 1);
         wstrb[j] = 8'hFF;
      end
      applyStimulus(1, 3, 3, 1, BASE + 64'h100, -1, 0, "t2_wr");
      applyStimulus(0, 3, 3, 1, BASE + 64'h100, -1, 0, "t2_rd");

      wdata[0] = 64'hAAAA; wdata[1] = 64'hBBBB; wdata[2] = 64'hCCCC; wdata[3] = 64'hDDDD;
      applyStimulus(1, 3, 3, 1, BASE, -1, 0, "t3_wr");
      applyStimulus(0, 3, 3, 2, BASE + 64'h10, -1, 0, "t3_wrap");

      wdata[0] = 64'd0; wstrb[0] = 8'hFF;
      applyStimulus(1, 3, 0, 1, BASE, -1, 0, "t4_clr");
      wdata[0] = 64'h00CD_0000; wstrb[0] = 8'b0000_0100;
      applyStimulus(1, 0, 0, 1, BASE + 64'h2, -1, 0, "t4_wr");
      applyStimulus(0, 3, 0, 1, BASE, -1, 0, "t4_rd");
      checkOutput("t4_model", model[0], 64'h00CD_0000);

      applyStimulus(0, 3, 0, 1, BASE - 64'h8, -1, 0, "t5_rd");
      wdata[0] = 64'hDEAD_BEEF_0BAD_F00D; wstrb[0] = 8'hFF;
      applyStimulus(1, 3, 0, 1, BASE - 64'h8, -1, 0, "t5_wr");
      applyStimulus(0, 3, 0, 1, BASE + 64'(MEM_WORDS - 1) * 64'd8, -1, 0, "t5_top");
      applyStimulus(0, 3, 0, 1, BASE, -1, 0, "t5_bot");

      for (int j = 0; j < 8; j++) begin
         wdata[j] = {$urandom, $urandom};
         wstrb[j] = 8'hFF;
      end
      applyStimulus(1, 3, 7, 1, BASE + 64'h200, 3, 0, "t6_drop");
      applyStimulus(0, 3, 7, 1, BASE + 64'h200, -1, 0, "t6_drop_rd");
      applyStimulus(1, 3, 7, 1, BASE + 64'h300, 3, 1, "t6_rst");
      applyStimulus(0, 3, 7, 1, BASE + 64'h300, -1, 0, "t6_rst_rd");

      for (int t = 0; t < 60; t++) begin
         isWrite = 1'($urandom_range(0, 1));
         size    = $urandom_range(0, 3);
         burst   = $urandom_range(0, 2);
         if (burst == 2) len = (1 << $urandom_range(1, 4)) - 1;
         else            len = $urandom_range(0, 15);
         if ($urandom_range(0, 7) == 0) addr = BASE - 64'($urandom_range(1, 64));
         else addr = BASE + 64'($urandom_range(0, MEM_WORDS * 8 - 1));
         addr = addr & ~((64'd1 << size) - 64'd1);
         abortAfter = (len > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len) : -1;
         for (int j = 0; j <= len; j++) begin
            wdata[j] = {$urandom, $urandom};
            wstrb[j] = 8'($urandom);
         end
         applyStimulus(isWrite, size, len, burst, addr, abortAfter, 1'($urandom_range(0, 1)), "rnd");
         if (isWrite) applyStimulus(0, size, len, burst, addr, -1, 0, "rnd_rb");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
